// File: rtl/hyst_level_counter_pkg.sv
// rtl/hyst_level_counter_pkg.sv - shared alarm FSM encoding and default threshold constants
package hyst_level_counter_pkg;

    typedef enum logic {
        ALARM_OFF = 1'b0,
        ALARM_ON  = 1'b1
    } alarm_state_t;

    localparam int DEF_WIDTH     = 3;
    localparam int DEF_MAX_COUNT = 7;
    localparam int DEF_ON_LEVEL  = 5;
    localparam int DEF_OFF_LEVEL = 2;

endpackage

// File: rtl/hyst_comparator.sv
// rtl/hyst_comparator.sv - two-threshold hysteresis flag on a registered value
module hyst_comparator
    import hyst_level_counter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ON_LEVEL  = DEF_ON_LEVEL,
    parameter int OFF_LEVEL = DEF_OFF_LEVEL
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    output logic             flag
);

    localparam logic [WIDTH-1:0] ON_L  = WIDTH'(ON_LEVEL);
    localparam logic [WIDTH-1:0] OFF_L = WIDTH'(OFF_LEVEL);

    alarm_state_t state, state_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ALARM_OFF;
        end else begin
            state <= state_next;
        end
    end

    // Values strictly between the thresholds leave the state untouched.
    always_comb begin
        state_next = state;
        case (state)
            ALARM_OFF: if (value >= ON_L)  state_next = ALARM_ON;
            ALARM_ON:  if (value <= OFF_L) state_next = ALARM_OFF;
            default:   state_next = ALARM_OFF;
        endcase
    end

    assign flag = (state == ALARM_ON);

endmodule

// File: rtl/hyst_level_counter.sv
// rtl/hyst_level_counter.sv - saturating up/down level counter with hysteresis alarm
module hyst_level_counter
    import hyst_level_counter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_COUNT = DEF_MAX_COUNT,
    parameter int ON_LEVEL  = DEF_ON_LEVEL,
    parameter int OFF_LEVEL = DEF_OFF_LEVEL
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             at_min,
    output logic             at_max,
    output logic             alarm,
    output logic             changed
);

    generate
        if (MAX_COUNT < 1 || MAX_COUNT > (2 ** WIDTH) - 1) begin : g_bad_max
            $error("hyst_level_counter: MAX_COUNT out of range for WIDTH");
        end
        if (!(OFF_LEVEL < ON_LEVEL && ON_LEVEL <= MAX_COUNT)) begin : g_bad_levels
            $error("hyst_level_counter: need OFF_LEVEL < ON_LEVEL <= MAX_COUNT");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_L = WIDTH'(1);

    logic [WIDTH-1:0] count_next;

    // Bounds are tested before the add/subtract so no carry or borrow is ever needed.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = (load_value > MAX_L) ? MAX_L : load_value;
        end else if (tick && up && !down) begin
            if (count != MAX_L) count_next = count + ONE_L;
        end else if (tick && down && !up) begin
            if (count != '0) count_next = count - ONE_L;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            changed <= 1'b0;
        end else begin
            count   <= count_next;
            changed <= (count_next != count);
        end
    end

    assign at_min = (count == '0);
    assign at_max = (count == MAX_L);

    hyst_comparator #(
        .WIDTH     (WIDTH),
        .ON_LEVEL  (ON_LEVEL),
        .OFF_LEVEL (OFF_LEVEL)
    ) u_alarm (
        .clock (clock),
        .reset (reset),
        .value (count),
        .flag  (alarm)
    );

endmodule

// File: tb/tb_hyst_level_counter.sv
// tb/tb_hyst_level_counter.sv - directed self-checking bench for hyst_level_counter
module tb_hyst_level_counter;

    logic       clock = 1'b0;
    logic       reset, tick, up, down, load;
    logic [2:0] load_value;
    logic [2:0] count;
    logic       at_min, at_max, alarm, changed;

    logic       w_reset, w_tick, w_up, w_down, w_load;
    logic [3:0] w_load_value;
    logic [3:0] w_count;
    logic       w_at_min, w_at_max, w_alarm, w_changed;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    hyst_level_counter dut (
        .clock(clock), .reset(reset), .tick(tick), .up(up), .down(down),
        .load(load), .load_value(load_value), .count(count), .at_min(at_min),
        .at_max(at_max), .alarm(alarm), .changed(changed)
    );

    hyst_level_counter #(.WIDTH(4), .MAX_COUNT(9)) dut_w (
        .clock(clock), .reset(w_reset), .tick(w_tick), .up(w_up), .down(w_down),
        .load(w_load), .load_value(w_load_value), .count(w_count), .at_min(w_at_min),
        .at_max(w_at_max), .alarm(w_alarm), .changed(w_changed)
    );

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset = 0; tick = 0; up = 0; down = 0; load = 0; load_value = 3'd0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; load = 1; load_value = 3'd6; tick = 1; up = 1;
        w_reset = 1; w_tick = 0; w_up = 0; w_down = 0; w_load = 0; w_load_value = 4'd0;
        cycle();
        cycle();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (at_min !== 1'b1) begin n_err++; $display("FAIL reset_at_min got %b want 1", at_min); end
        n_cmp++; if (at_max !== 1'b0) begin n_err++; $display("FAIL reset_at_max got %b want 0", at_max); end
        n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL reset_alarm got %b want 0", alarm); end
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL reset_changed got %b want 0", changed); end
        idle();
        w_reset = 0;
    endtask

    task automatic test_up_saturate();
        logic [2:0] exp_c;
        idle(); tick = 1; up = 1;
        for (int i = 1; i <= 9; i++) begin
            cycle();
            exp_c = (i < 7) ? 3'(i) : 3'd7;
            n_cmp++; if (count !== exp_c) begin n_err++; $display("FAIL up_count[%0d] got %0d want %0d", i, count, exp_c); end
            n_cmp++; if (changed !== (i <= 7)) begin n_err++; $display("FAIL up_changed[%0d] got %b want %b", i, changed, i <= 7); end
            n_cmp++; if (at_max !== (i >= 7)) begin n_err++; $display("FAIL up_at_max[%0d] got %b want %b", i, at_max, i >= 7); end
            n_cmp++; if (alarm !== (i >= 6)) begin n_err++; $display("FAIL up_alarm[%0d] got %b want %b", i, alarm, i >= 6); end
        end
        idle();
    endtask

    task automatic test_down_saturate();
        logic [2:0] exp_c;
        idle(); tick = 1; down = 1;
        for (int i = 1; i <= 9; i++) begin
            cycle();
            exp_c = (i < 7) ? 3'(7 - i) : 3'd0;
            n_cmp++; if (count !== exp_c) begin n_err++; $display("FAIL down_count[%0d] got %0d want %0d", i, count, exp_c); end
            n_cmp++; if (changed !== (i <= 7)) begin n_err++; $display("FAIL down_changed[%0d] got %b want %b", i, changed, i <= 7); end
            n_cmp++; if (at_min !== (i >= 7)) begin n_err++; $display("FAIL down_at_min[%0d] got %b want %b", i, at_min, i >= 7); end
            n_cmp++; if (alarm !== (i < 6)) begin n_err++; $display("FAIL down_alarm[%0d] got %b want %b", i, alarm, i < 6); end
        end
        idle();
    endtask

    task automatic test_hysteresis();
        int         ops   [7] = '{1, 0, 2, 2, 0, 2, 0};
        logic [2:0] exp_c [7] = '{3'd5, 3'd5, 3'd4, 3'd3, 3'd3, 3'd2, 3'd2};
        logic       exp_a [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        idle(); load = 1; load_value = 3'd4;
        cycle();
        idle();
        cycle();
        n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL hyst_alarm_at4 got %b want 0", alarm); end
        for (int i = 0; i < 7; i++) begin
            idle();
            tick = (ops[i] != 0); up = (ops[i] == 1); down = (ops[i] == 2);
            cycle();
            n_cmp++; if (count !== exp_c[i]) begin n_err++; $display("FAIL hyst_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
            n_cmp++; if (alarm !== exp_a[i]) begin n_err++; $display("FAIL hyst_alarm[%0d] got %b want %b", i, alarm, exp_a[i]); end
        end
        idle();
    endtask

    task automatic test_hold();
        idle(); tick = 1; up = 1; down = 1;
        cycle();
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL hold_updown_count got %0d want 2", count); end
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL hold_updown_changed got %b want 0", changed); end
        idle(); up = 1;
        cycle();
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL hold_notick_count got %0d want 2", count); end
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL hold_notick_changed got %b want 0", changed); end
        idle();
    endtask

    task automatic test_load();
        idle(); reset = 1;
        cycle();
        idle(); load = 1; load_value = 3'd7; tick = 1; down = 1;
        cycle();
        n_cmp++; if (count !== 3'd7) begin n_err++; $display("FAIL load7_count got %0d want 7", count); end
        n_cmp++; if (changed !== 1'b1) begin n_err++; $display("FAIL load7_changed got %b want 1", changed); end
        n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL load7_alarm_same got %b want 0", alarm); end
        idle();
        cycle();
        n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("FAIL load7_alarm_next got %b want 1", alarm); end
        idle(); load = 1; load_value = 3'd7;
        cycle();
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL load_equal_changed got %b want 0", changed); end
        idle(); load = 1; load_value = 3'd0; tick = 1; up = 1;
        cycle();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL load0_count got %0d want 0", count); end
        n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("FAIL load0_alarm_same got %b want 1", alarm); end
        idle();
        cycle();
        n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL load0_alarm_next got %b want 0", alarm); end
    endtask

    task automatic test_wide_clamp();
        w_load = 1; w_load_value = 4'd15;
        cycle();
        n_cmp++; if (w_count !== 4'd9) begin n_err++; $display("FAIL wide_clamp_count got %0d want 9", w_count); end
        n_cmp++; if (w_at_max !== 1'b1) begin n_err++; $display("FAIL wide_at_max got %b want 1", w_at_max); end
        n_cmp++; if (w_changed !== 1'b1) begin n_err++; $display("FAIL wide_clamp_changed got %b want 1", w_changed); end
        w_load_value = 4'd12;
        cycle();
        n_cmp++; if (w_changed !== 1'b0) begin n_err++; $display("FAIL wide_reclamp_changed got %b want 0", w_changed); end
        n_cmp++; if (w_alarm !== 1'b1) begin n_err++; $display("FAIL wide_alarm got %b want 1", w_alarm); end
        w_load = 0; w_tick = 1; w_up = 1;
        cycle();
        n_cmp++; if (w_count !== 4'd9) begin n_err++; $display("FAIL wide_sat_count got %0d want 9", w_count); end
        n_cmp++; if (w_changed !== 1'b0) begin n_err++; $display("FAIL wide_sat_changed got %b want 0", w_changed); end
        w_tick = 0; w_up = 0; w_load = 1; w_load_value = 4'd3;
        cycle();
        n_cmp++; if (w_count !== 4'd3) begin n_err++; $display("FAIL wide_load3_count got %0d want 3", w_count); end
        n_cmp++; if (w_at_max !== 1'b0) begin n_err++; $display("FAIL wide_load3_at_max got %b want 0", w_at_max); end
        w_load = 0;
    endtask

    task automatic test_reset_mid();
        idle(); load = 1; load_value = 3'd6;
        cycle();
        idle();
        cycle();
        n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("FAIL mid_pre_alarm got %b want 1", alarm); end
        reset = 1; load = 1; load_value = 3'd7; tick = 1; up = 1;
        cycle();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL mid_count got %0d want 0", count); end
        n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL mid_alarm got %b want 0", alarm); end
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL mid_changed got %b want 0", changed); end
        idle();
        cycle();
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL mid_after_changed got %b want 0", changed); end
        n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL mid_after_alarm got %b want 0", alarm); end
    endtask

    initial begin
        test_reset();
        test_up_saturate();
        test_down_saturate();
        test_hysteresis();
        test_hold();
        test_load();
        test_wide_clamp();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hyst_level_counter.md
HYST_LEVEL_COUNTER -- requirements
Module: hyst_level_counter

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits.
REQ-002 Parameter MAX_COUNT, default 7: upper saturation value, 1 <= MAX_COUNT <= 2^WIDTH-1.
REQ-003 Parameter ON_LEVEL, default 5: count at or above which alarm asserts.
REQ-004 Parameter OFF_LEVEL, default 2: count at or below which alarm deasserts; OFF_LEVEL < ON_LEVEL <= MAX_COUNT.
REQ-005 clock  input  1  single system clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 tick  input  1  step qualifier; up/down act only in cycles where tick=1.
REQ-008 up  input  1  request increment by one.
REQ-009 down  input  1  request decrement by one.
REQ-010 load  input  1  synchronous load of load_value, ignores tick.
REQ-011 load_value  input  WIDTH  value to load.
REQ-012 count  output  WIDTH  registered current count.
REQ-013 at_min  output  1  count == 0.
REQ-014 at_max  output  1  count == MAX_COUNT.
REQ-015 alarm  output  1  registered hysteresis flag.
REQ-016 changed  output  1  one-cycle pulse when count took a new value at the last edge.

Function
REQ-017 Update priority per edge SHALL be: reset > load > step > hold.
REQ-018 load=1: count <= min(load_value, MAX_COUNT); tick, up and down ignored that cycle.
REQ-019 Step cycle (tick=1, load=0): up=1,down=0 -> count+1; up=0,down=1 -> count-1; up=down -> hold.
REQ-020 Increment at count==MAX_COUNT SHALL hold (saturate, no wrap).
REQ-021 Decrement at count==0 SHALL hold (saturate, no wrap to MAX).
REQ-022 tick=0 and load=0: count holds regardless of up/down.
REQ-023 at_min, at_max SHALL be combinational decodes of registered count (zero latency relative to count).
REQ-024 changed SHALL be registered: 1 in the cycle after an edge where count's new value differs from its old value; saturated step, load of equal value, and hold give changed=0.
REQ-025 Alarm FSM states: OFF, ON; encoded as a 1-bit state register driving alarm directly.
REQ-026 OFF -> ON when registered count >= ON_LEVEL; ON -> OFF when registered count <= OFF_LEVEL; otherwise stay.
REQ-027 Alarm SHALL lag count by exactly one cycle (evaluated on registered count, not next-count).
REQ-028 Counts strictly between OFF_LEVEL and ON_LEVEL SHALL never change alarm.
REQ-029 A load jumping across both thresholds SHALL flip alarm one cycle after count updates, with no intermediate state.
REQ-030 All arithmetic in WIDTH bits with explicit saturation checks before add/subtract; no carry-out used.

Reset
REQ-031 reset=1 at an edge: count <= 0, alarm FSM <= OFF, changed <= 0; overrides load and step.
REQ-032 After reset: count=0, at_min=1, at_max=0, alarm=0, changed=0.
REQ-033 Reset asserted mid-operation (any state, alarm ON) SHALL take effect at the next edge with no residual pulse on changed.

Structure
REQ-034 Alarm state encoding (OFF/ON) and default threshold constants SHALL live in the shared fsm package used by the irrigation FSMs.
REQ-035 Hysteresis comparator SHALL be a sub-module hyst_comparator (inputs clock, reset, value; output flag), reusable for moisture levels.
REQ-036 Parameter legality (REQ-002, REQ-004) SHALL be checked at elaboration and fail on violation.

Verification
REQ-037 Defaults; reset, then tick=1, up=1 for 9 cycles -> count 1..7 then holds 7; at_max=1 from count=7; changed=0 after saturation.
REQ-038 From 7, tick=1, down=1 for 9 cycles -> count reaches 0 and holds; at_min=1; alarm 1->0 one cycle after count=2.
REQ-039 Count 4, alarm OFF; step to 5 -> alarm=1 next cycle; step down to 3 -> alarm stays 1; to 2 -> alarm=0 next cycle.
REQ-040 tick=1, up=down=1 -> count holds, changed=0; tick=0, up=1 -> count holds.
REQ-041 load=1, load_value=7 from count 0 with tick=1, down=1 -> count=7, alarm=1 one cycle later; WIDTH=4, MAX_COUNT=9, load_value=15 -> count=9.
REQ-042 Count 6, alarm ON, reset pulsed with load=1 -> count=0, alarm=0, changed=0 next cycle.
